// File: rtl/image_mem_arbiter_pkg.sv
// Shared definitions for the image RAM arbiter: default geometry, FSM encoding,
// port indices and the in-flight read tag.
package image_mem_arbiter_pkg;

  localparam int unsigned DEF_RAM_WIDTH     = 24;
  localparam int unsigned DEF_RAM_ADDR_BITS = 10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic valid;
    logic port;
  } rsp_tag_t;

endpackage

// File: rtl/image_mem_arbiter_if.sv
// Requester, clear-engine and RAM-side signals of the image RAM arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface image_mem_arbiter_if #(
  parameter int unsigned RAM_WIDTH     = image_mem_arbiter_pkg::DEF_RAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS = image_mem_arbiter_pkg::DEF_RAM_ADDR_BITS
);

  logic                     req0_valid;
  logic                     req0_we;
  logic [RAM_ADDR_BITS-1:0] req0_addr;
  logic [RAM_WIDTH-1:0]     req0_wdata;
  logic                     req0_ready;
  logic                     rsp0_valid;
  logic [RAM_WIDTH-1:0]     rsp0_data;

  logic                     req1_valid;
  logic                     req1_we;
  logic [RAM_ADDR_BITS-1:0] req1_addr;
  logic [RAM_WIDTH-1:0]     req1_wdata;
  logic                     req1_ready;
  logic                     rsp1_valid;
  logic [RAM_WIDTH-1:0]     rsp1_data;

  logic                     clr_start;
  logic [RAM_WIDTH-1:0]     clr_value;
  logic                     clr_busy;
  logic                     clr_done;

  logic                     mem_we;
  logic [RAM_ADDR_BITS-1:0] mem_addr;
  logic [RAM_WIDTH-1:0]     mem_di;
  logic [RAM_WIDTH-1:0]     mem_do;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_data,
    input  clr_start, clr_value,
    output clr_busy, clr_done,
    output mem_we, mem_addr, mem_di,
    input  mem_do
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_data,
    output clr_start, clr_value,
    input  clr_busy, clr_done,
    input  mem_we, mem_addr, mem_di,
    output mem_do
  );

endinterface

// File: rtl/image_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant only moves when both ports contend,
// and resets to port 1 so port 0 wins the first contention.
module rr_arbiter2
  import image_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt_c
);

  logic       r_last_grant;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_last_grant == PORT1) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign o_gnt_c = w_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT1;
    end else if (i_en && (i_req == 2'b11)) begin
      r_last_grant <= w_gnt[1];
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Shares a single-port image RAM between two requesters with a registered
// command stage, 2-cycle tagged read return and a full-memory clear sweep.
module image_mem_arbiter
  import image_mem_arbiter_pkg::*;
#(
  parameter int unsigned RAM_WIDTH     = DEF_RAM_WIDTH,
  parameter int unsigned RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  image_mem_arbiter_if.slave bus
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST_ADDR = '1;

  state_t                   r_state;
  logic [RAM_ADDR_BITS-1:0] r_cnt;
  logic                     r_mem_we;
  logic [RAM_ADDR_BITS-1:0] r_mem_addr;
  logic [RAM_WIDTH-1:0]     r_mem_di;
  logic                     r_clr_busy;
  logic                     r_clr_done;
  rsp_tag_t                 r_tag1;
  rsp_tag_t                 r_tag2;

  logic                     w_arb_en;
  logic [1:0]               w_gnt;
  logic                     w_hs;
  logic                     w_sel;
  logic                     w_we;
  logic [RAM_ADDR_BITS-1:0] w_addr;
  logic [RAM_WIDTH-1:0]     w_wdata;
  logic                     w_rsp0;
  logic                     w_rsp1;

  // Grants only in IDLE, and never in the cycle a clear is requested.
  assign w_arb_en = (r_state == ST_IDLE) && !bus.clr_start;

  rr_arbiter2 u_rr_arbiter2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_arb_en),
    .i_req   ({bus.req1_valid, bus.req0_valid}),
    .o_gnt_c (w_gnt)
  );

  assign bus.req0_ready = w_gnt[PORT0];
  assign bus.req1_ready = w_gnt[PORT1];

  assign w_hs    = |w_gnt;
  assign w_sel   = w_gnt[PORT1];
  assign w_we    = w_sel ? bus.req1_we    : bus.req0_we;
  assign w_addr  = w_sel ? bus.req1_addr  : bus.req0_addr;
  assign w_wdata = w_sel ? bus.req1_wdata : bus.req0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_di   <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
      r_tag1     <= '0;
      r_tag2     <= '0;
    end else begin
      r_tag1.valid <= w_hs && !w_we;
      r_tag1.port  <= w_sel;
      r_tag2       <= r_tag1;
      r_clr_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            // mem_di doubles as the latched fill value for the whole sweep.
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_mem_we   <= 1'b1;
            r_mem_addr <= '0;
            r_mem_di   <= bus.clr_value;
            r_clr_busy <= 1'b1;
          end else begin
            r_mem_we <= w_hs && w_we;
            if (w_hs) begin
              r_mem_addr <= w_addr;
              if (w_we) r_mem_di <= w_wdata;
            end
          end
        end
        ST_CLEAR: begin
          if (r_cnt == LAST_ADDR) begin
            r_state    <= ST_IDLE;
            r_mem_we   <= 1'b0;
            r_clr_busy <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + RAM_ADDR_BITS'(1);
            r_mem_addr <= r_cnt + RAM_ADDR_BITS'(1);
            r_clr_done <= (r_cnt == (LAST_ADDR - RAM_ADDR_BITS'(1)));
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_di   = r_mem_di;
  assign bus.clr_busy = r_clr_busy;
  assign bus.clr_done = r_clr_done;

  // RAM output is valid two cycles after the grant; route it to the owning port.
  assign w_rsp0 = r_tag2.valid && (r_tag2.port == PORT0);
  assign w_rsp1 = r_tag2.valid && (r_tag2.port == PORT1);

  assign bus.rsp0_valid = w_rsp0;
  assign bus.rsp1_valid = w_rsp1;
  assign bus.rsp0_data  = w_rsp0 ? bus.mem_do : '0;
  assign bus.rsp1_data  = w_rsp1 ? bus.mem_do : '0;

endmodule

// File: doc/image_mem_arbiter.md
Name: image_mem_arbiter

Overview:
Controller that shares the single-port inferred image RAM (24-bit words, 1024 deep, one access per clock, 1-cycle registered read) between two requesters. Port 0 is the pixel/display fetch side; port 1 is the loader/processing side. Adds a built-in clear engine that sweeps a constant into every word. Sits between the requesters and the RAM and owns the RAM's write_enable, addr and DI inputs.

Parameters:
RAM_WIDTH, 24, data word width; must match the RAM instance.
RAM_ADDR_BITS, 10, address width; depth = 2**RAM_ADDR_BITS.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
req0_valid  in  1  port 0 access request
req0_we  in  1  port 0: 1 = write, 0 = read
req0_addr  in  RAM_ADDR_BITS  port 0 address
req0_wdata  in  RAM_WIDTH  port 0 write data
req0_ready  out  1  port 0 grant; transfer when valid & ready
rsp0_valid  out  1  port 0 read data valid
rsp0_data  out  RAM_WIDTH  port 0 read data
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_data: same as port 0, for port 1
clr_start  in  1  one-cycle pulse: start clear sweep
clr_value  in  RAM_WIDTH  fill value, sampled with clr_start
clr_busy  out  1  clear sweep in progress
clr_done  out  1  one-cycle pulse on final clear write
mem_we  out  1  to RAM write_enable
mem_addr  out  RAM_ADDR_BITS  to RAM addr
mem_di  out  RAM_WIDTH  to RAM DI
mem_do  in  RAM_WIDTH  from RAM DO

Behaviour:
- Reset (async assert, sync release): mem_we=0, mem_addr=0, mem_di=0, rsp0_valid=rsp1_valid=0, rspN_data=0, clr_busy=0, clr_done=0, FSM=IDLE, round-robin last_grant=1, so port 0 wins the first contention.
- FSM states: IDLE, CLEAR.
- IDLE, grant logic is combinational from the current inputs:
  - clr_start=1: no grant this cycle, latch clr_value, go to CLEAR.
  - Otherwise, if exactly one port is valid, that port gets ready.
  - If both are valid, the port != last_grant gets ready; last_grant updates to the winner.
  - At most one readyN high per cycle. ready is never asserted when a port is not valid.
- Command stage (registered): a handshake in cycle T drives mem_we/mem_addr/mem_di in cycle T+1.
  - With no handshake, mem_we=0 and addr/di hold their previous values.
- Read response: the RAM registers DO at the T+1 edge, so mem_do is valid in T+2.
  - rspN_valid=1 in T+2 for the granting port only; rspN_data = mem_do (combinational pass-through).
  - Total read latency is 2 cycles. Back-to-back reads yield back-to-back responses, throughput 1/clk.
  - A 2-entry shift register of {valid, port} tags tracks responses in flight.
- Writes produce no response.
- Read-after-write to the same address in consecutive grants returns the new data, because the RAM commits on the T+1 edge.
- CLEAR:
  - A counter runs 0..2**RAM_ADDR_BITS-1, one write per cycle: mem_we=1, mem_addr=count, mem_di=latched clr_value.
  - clr_busy=1 throughout; both readyN=0.
  - clr_done=1 in the cycle the last address (1023) is driven on mem_*; the FSM then returns to IDLE.
  - Sequence: start at T, first write at T+1, done at T+1024, grants possible from T+1025.
  - Reads granted before entering CLEAR still return their responses normally.
  - clr_start while in CLEAR is ignored.
- rst_n asserted mid-CLEAR: sweep aborts, all outputs take reset values, RAM contents are undefined/partial.
- Address wrap: the counter never wraps. Terminal count forces the exit from CLEAR.

Decomposition:
- Shared package: RAM_WIDTH/RAM_ADDR_BITS defaults, FSM state encoding (IDLE=0, CLEAR=1), port index constants (PORT0=0, PORT1=1).
- One natural sub-module: rr_arbiter2, the 2-way round-robin with last_grant register. Everything else stays in image_mem_arbiter.

Test Plan:
- Reset defaults: hold rst_n low, toggle clk -> all outputs 0, readyN=0. Release, then req0 read addr 5 -> req0_ready=1 same cycle, mem_addr=5 next cycle.
- Read latency: preload word 0x3FF=0xABCDEF, port 1 reads 0x3FF at T -> rsp1_valid=1, rsp1_data=0xABCDEF exactly at T+2, rsp0_valid stays 0.
- Contention: both valid for 4 cycles, reads at addrs 1 (p0) and 2 (p1) -> grants p0, p1, p0, p1; responses alternate ports two cycles later.
- RAW: p0 writes 0x123456 to addr 10 at T, p0 reads addr 10 at T+1 -> rsp0_data=0x123456 at T+3.
- Clear: clr_start with clr_value=0x00FF00 at T while p1 is valid -> no ready T..T+1024, clr_busy T+1..T+1024, clr_done only at T+1024. Reading any of addrs 0, 512, 1023 afterwards returns 0x00FF00.
- Reset mid-clear: pulse rst_n low at T+300 -> clr_busy=0, FSM IDLE, mem_we=0 immediately; a new clr_start runs the full 1024-write sweep.
